// File: rtl/recv_422_order_pkg.sv
// Shared definitions for the RS422 order receiver: FSM encodings,
// UART frame constants and baud divider helper.
package recv_422_order_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam bit          PARITY_EVEN = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [0:0] {
    WAIT_HI,
    WAIT_LO
  } asm_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/recv_422_order_uart_rx.sv
// UART byte receiver: 2-flop synchroniser plus start/data/parity/stop
// bit FSM with even-parity and stop-bit checking.
module uart_rx_even_check
  import recv_422_order_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_done,
  output logic [7:0] rx_data,
  output logic       parity_ok,
  output logic       stop_ok,
  output logic       false_start,
  output logic       busy
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic [1:0]    sync;
  logic          rxd_s;
  logic          rxd_prev;
  logic          fall;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          tick;
  rx_state_t     state, state_n;

  assign rxd_s = sync[1];
  assign fall  = rxd_prev & ~rxd_s;
  assign tick  = (state == RX_START) ? (clk_cnt == CW'(HALF - 1))
                                     : (clk_cnt == CW'(CLKS_PER_BIT - 1));

  // Synchronise the asynchronous line and keep one extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '1;
      rxd_prev <= 1'b1;
    end else begin
      sync     <= {sync[0], rxd};
      rxd_prev <= rxd_s;
    end
  end

  // Bit receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_n;
  end

  // Bit receiver next-state logic
  always_comb begin
    state_n = state;
    case (state)
      RX_IDLE:   if (fall) state_n = RX_START;
      RX_START:  if (tick) state_n = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:   if (tick && bit_cnt == 3'(DATA_BITS - 1)) state_n = RX_PARITY;
      RX_PARITY: if (tick) state_n = RX_STOP;
      RX_STOP:   if (tick) state_n = RX_IDLE;
      default:   state_n = RX_IDLE;
    endcase
  end

  // Bit receiver outputs: one-cycle strobes at the sampling points
  always_comb begin
    byte_done   = (state == RX_STOP) && tick;
    false_start = (state == RX_START) && tick && rxd_s;
    stop_ok     = rxd_s;
    rx_data     = shreg;
    parity_ok   = PARITY_EVEN ? ~^{shreg, par_bit} : ^{shreg, par_bit};
    busy        = (state != RX_IDLE);
  end

  // Bit timing counter, data shift register and parity capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (state == RX_IDLE || tick) clk_cnt <= '0;
      else                          clk_cnt <= clk_cnt + CW'(1);
      if (state == RX_IDLE) begin
        bit_cnt <= '0;
      end else if (state == RX_DATA && tick) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == RX_PARITY && tick) par_bit <= rxd_s;
    end
  end

endmodule

// File: rtl/recv_422_order.sv
// RS422 order receiver: pairs two good UART bytes (high first) into a
// 16-bit order, dropping and flagging corrupt, truncated or stalled pairs.
module recv_422_order
  import recv_422_order_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned GAP_BITS  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RXD,
  output logic [15:0] order_out,
  output logic        order_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        timeout_err
);

  localparam int unsigned CPB       = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned GAP_LIMIT = GAP_BITS * CPB;

  logic        byte_done, parity_ok, stop_ok, false_start, busy;
  logic [7:0]  rx_data;
  logic [7:0]  hi_byte;
  logic [31:0] gap_cnt;
  logic        good, gap_hit, load_hi, emit;
  asm_state_t  state, state_n;

  uart_rx_even_check #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (RXD),
    .byte_done   (byte_done),
    .rx_data     (rx_data),
    .parity_ok   (parity_ok),
    .stop_ok     (stop_ok),
    .false_start (false_start),
    .busy        (busy)
  );

  assign good    = byte_done & parity_ok & stop_ok;
  // gap counter only advances while the line is idle, so a started low byte freezes it
  assign gap_hit = (state == WAIT_LO) && !busy && (gap_cnt == GAP_LIMIT - 1);

  // Assembler state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_HI;
    else        state <= state_n;
  end

  // Assembler next-state logic
  always_comb begin
    state_n = state;
    case (state)
      WAIT_HI: if (good) state_n = WAIT_LO;
      WAIT_LO: if (byte_done || gap_hit) state_n = WAIT_HI;
      default: state_n = WAIT_HI;
    endcase
  end

  // Assembler output decode
  always_comb begin
    load_hi = (state == WAIT_HI) && good;
    emit    = (state == WAIT_LO) && good;
  end

  // Registered order word, pulse outputs and inter-byte gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte     <= '0;
      order_out   <= '0;
      order_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      order_valid <= emit;
      parity_err  <= byte_done & ~parity_ok;
      frame_err   <= (byte_done & ~stop_ok) | false_start;
      timeout_err <= gap_hit;
      if (load_hi) hi_byte <= rx_data;
      if (emit)    order_out <= {hi_byte, rx_data};
      if (load_hi)
        gap_cnt <= '0;
      else if (state == WAIT_LO && !busy && gap_cnt != GAP_LIMIT - 1)
        gap_cnt <= gap_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_recv_422_order.sv
// Directed self-checking bench for recv_422_order at 10 clocks per bit.
module tb_recv_422_order;

  localparam int CPB = 10;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic [15:0] order_out;
  logic        order_valid, parity_err, frame_err, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_par    = 0;
  int n_frame  = 0;
  int n_to     = 0;
  int b_valid, b_par, b_frame, b_to;

  recv_422_order #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000),
    .GAP_BITS  (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RXD         (rxd),
    .order_out   (order_out),
    .order_valid (order_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of each pulse output
  always @(negedge clk) begin
    if (order_valid) n_valid++;
    if (parity_err)  n_par++;
    if (frame_err)   n_frame++;
    if (timeout_err) n_to++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ flip_par);
    send_bit(stop_bit);
    rxd = 1'b1;
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_par   = n_par;
    b_frame = n_frame;
    b_to    = n_to;
  endtask

  initial begin
    logic [7:0] rb;
    rxd   = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_order",  32'(order_out),   32'h0);
    check("rst_valid",  32'(order_valid), 32'h0);
    check("rst_par",    32'(parity_err),  32'h0);
    check("rst_frame",  32'(frame_err),   32'h0);
    check("rst_to",     32'(timeout_err), 32'h0);
    rst_n = 1'b1;
    idle_bits(2);

    // back-to-back good pair
    snap();
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    check("a53c_valid", 32'(n_valid - b_valid), 32'd1);
    check("a53c_order", 32'(order_out),         32'hA53C);
    check("a53c_par",   32'(n_par - b_par),     32'd0);
    check("a53c_frame", 32'(n_frame - b_frame), 32'd0);
    check("a53c_to",    32'(n_to - b_to),       32'd0);

    // bad parity byte is dropped, following pair assembles
    snap();
    send_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h34, 1'b0, 1'b1);
    send_frame(8'h56, 1'b0, 1'b1);
    idle_bits(2);
    check("par_err",    32'(n_par - b_par),     32'd1);
    check("par_valid",  32'(n_valid - b_valid), 32'd1);
    check("par_order",  32'(order_out),         32'h3456);
    check("par_frame",  32'(n_frame - b_frame), 32'd0);

    // low stop bit on second byte
    snap();
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0);
    idle_bits(2);
    check("stop_frame", 32'(n_frame - b_frame), 32'd1);
    check("stop_valid", 32'(n_valid - b_valid), 32'd0);
    check("stop_order", 32'(order_out),         32'h3456);

    // gap timeout between high and low byte
    snap();
    send_frame(8'h81, 1'b0, 1'b1);
    idle_bits(19);
    check("to_early",   32'(n_to - b_to),       32'd0);
    idle_bits(2);
    check("to_fired",   32'(n_to - b_to),       32'd1);
    idle_bits(4);
    send_frame(8'h02, 1'b0, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    idle_bits(2);
    check("to_valid",   32'(n_valid - b_valid), 32'd1);
    check("to_order",   32'(order_out),         32'h0203);
    check("to_once",    32'(n_to - b_to),       32'd1);

    // short glitch on idle line is a false start
    snap();
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(2);
    check("gl_frame",   32'(n_frame - b_frame), 32'd1);
    check("gl_valid",   32'(n_valid - b_valid), 32'd0);
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle_bits(2);
    check("gl_order",   32'(order_out),         32'h1122);
    check("gl_valid2",  32'(n_valid - b_valid), 32'd1);

    // reset in the middle of data bit 4 of a high byte
    rb = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rb[i]);
    rxd = rb[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_order",   32'(order_out),   32'h0);
    check("mr_valid",   32'(order_valid), 32'h0);
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    snap();
    send_frame(8'hBE, 1'b0, 1'b1);
    send_frame(8'hEF, 1'b0, 1'b1);
    idle_bits(2);
    check("mr_beef",    32'(order_out),         32'hBEEF);
    check("mr_valid2",  32'(n_valid - b_valid), 32'd1);
    check("mr_errs",    32'((n_par - b_par) + (n_frame - b_frame) + (n_to - b_to)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/recv_422_order.md
# recv_422_order

Receive side of the RS422 command/feedback link: deserialises UART frames (1 start, 8 data LSB-first, even parity, 1 stop) from RXD and assembles two consecutive bytes, high byte first, into a 16-bit order word. It sits between the RS422 receiver pin and the command decoder. Corrupt, truncated or stalled frames are dropped and flagged, never forwarded.

## Interface
- CLK_FREQ, 50_000_000, clk frequency in Hz
- BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be ≥ 8)
- GAP_BITS, 20, maximum idle bit-times allowed between high-byte stop and low-byte start
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- RXD  input  1  serial line, idle high, asynchronous to clk
- order_out  output  16  last assembled order {byte1, byte2}; reset 16'h0000; holds until next valid order
- order_valid  output  1  one-cycle pulse when order_out updates; reset 0
- parity_err  output  1  one-cycle pulse on a byte with odd parity over data+parity bit; reset 0
- frame_err  output  1  one-cycle pulse on a stop bit sampled low or a false start; reset 0
- timeout_err  output  1  one-cycle pulse when the low byte does not start within GAP_BITS; reset 0

## Operation
- RXD passes through a 2-flop synchroniser (reset to 1) before any use.
- Bit receiver FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: falling edge on synchronised RXD → START, bit counter cleared.
  - START: at CLKS_PER_BIT/2 sample; high → false start, frame_err pulse, back to IDLE; low → DATA.
  - DATA: sample every CLKS_PER_BIT (mid-bit), shift in LSB first, 8 bits → PARITY.
  - PARITY: sample parity bit; compute parity_ok = ~^{data, p}.
  - STOP: sample at mid stop bit; emit byte_done with data, parity_ok, stop_ok; → IDLE immediately (no wait for bit end), so back-to-back frames are accepted.
- Assembler FSM: WAIT_HI, WAIT_LO.
  - WAIT_HI: byte_done good → latch high byte, start gap counter, → WAIT_LO.
  - WAIT_LO: byte_done good → order_out <= {hi, byte}, order_valid pulse, → WAIT_HI.
  - Gap counter counts clocks from high-byte stop sample; reaching GAP_BITS*CLKS_PER_BIT with bit receiver still in IDLE → timeout_err pulse, high byte discarded, → WAIT_HI. Counter frozen once a start bit is detected.
  - Any bad byte (parity or stop) in either state: corresponding error pulse, partial order discarded, → WAIT_HI. Parity and frame errors on the same byte pulse both.
- order_out never changes except with order_valid.
- Reset mid-frame: all state to IDLE/WAIT_HI, outputs to reset values; the in-flight frame is lost; receiver resynchronises on the next falling edge after RXD returns high.

## Timing
- Sampling points relative to detected falling edge (post-synchroniser): start at CLKS_PER_BIT/2, data bit n at CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT, parity at +9·CLKS_PER_BIT, stop at +10·CLKS_PER_BIT.
- order_valid asserts exactly 1 clk after the low-byte stop sample; error pulses same cycle as order_valid would.
- Synchroniser adds 2 clk latency from pin to edge detection.
- No back-pressure: downstream must accept order_valid in the pulse cycle.

## Structure
- Shared package: state encodings for both FSMs, UART frame constants (DATA_BITS = 8, parity mode EVEN), CLKS_PER_BIT derivation helper.
- Sub-module uart_rx_even_check: synchroniser + bit receiver FSM, outputs byte_done, rx_data[7:0], parity_ok, stop_ok, false_start, busy. Top level holds assembler FSM and gap counter.

## Test plan
- CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clk/bit): send 0xA5, 0x3C back-to-back → single order_valid, order_out=16'hA53C, no error pulses.
- Send 0x12 with parity bit flipped, then 0x34, 0x56 → parity_err once, 0x34/0x56 assembled as order 16'h3456.
- Send 0xFF then drive stop bit low on 0x00 → frame_err pulse, no order_valid, order_out unchanged.
- Send 0x81, idle 25 bit-times, send 0x02, 0x03 → timeout_err after 20 bit-times, then order 16'h0203.
- 3-clk low glitch on idle RXD → frame_err (false start), no byte_done, next valid pair decodes correctly.
- Assert rst_n low during data bit 4 of high byte → all outputs reset immediately; following pair 0xBE, 0xEF → order_out=16'hBEEF.
